// File: rtl/piso_tx_pkg.sv
// Shared definitions for the piso_tx serial transmitter.
package piso_tx_pkg;

    // Transmitter state: IDLE waits for a word, SHIFT drives one bit per cycle.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Width of the bit counter for a given word width (at least one bit).
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_tx_shift_bit.sv
// One slice of the transmit shift register: load / shift / hold select
// (two 2:1 muxes) feeding a single flop that clears under reset.
module shift_bit (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic shift,
    input  logic load_bit,
    input  logic shift_in,
    output logic q
);

    logic shift_or_hold_s;
    logic d_s;

    // First mux selects the neighbouring bit when shifting, else holds.
    always_comb begin
        shift_or_hold_s = q;
        if (shift) begin
            shift_or_hold_s = shift_in;
        end else begin
            shift_or_hold_s = q;
        end
    end

    // Second mux gives a new parallel word priority over shift/hold.
    always_comb begin
        d_s = shift_or_hold_s;
        if (load) begin
            d_s = load_bit;
        end else begin
            d_s = shift_or_hold_s;
        end
    end

    // Slice flop with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d_s;
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in / serial-out transmitter: accepts a WIDTH-bit word over
// valid/ready and sends it MSB-first on ser_o with frame_o marking bit times.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             ser_o,
    output logic             frame_o
);

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [WIDTH-1:0]   sr_r;
    logic               last_s;
    logic               ready_s;
    logic               accept_s;
    logic               shifting_s;

    // Last-bit detect, ready and accept; ready never depends on valid_i.
    always_comb begin
        shifting_s = (state_r == SHIFT);
        last_s     = shifting_s && (cnt_r == LAST_CNT);
        ready_s    = !rst_i && ((state_r == IDLE) || last_s);
        accept_s   = valid_i && ready_s;
    end

    // Next-state logic: an accept always (re)starts a frame, otherwise the
    // frame ends after its last bit.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (accept_s) begin
                    state_nxt_s = SHIFT;
                end else if (last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Bit counter: reloads on accept, stops at the last bit (no wrap).
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (accept_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (shifting_s && !last_s) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State and counter flops with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Shift register slices; bit 0 shifts in a zero so the register is
    // empty once a frame has fully drained.
    for (genvar k = 0; k < WIDTH; k++) begin : g_sr
        logic shift_in_s;
        if (k == 0) begin : g_lsb
            assign shift_in_s = 1'b0;
        end else begin : g_upper
            assign shift_in_s = sr_r[k-1];
        end
        shift_bit u_bit (
            .clk      (clk_i),
            .rst      (rst_i),
            .load     (accept_s),
            .shift    (shifting_s),
            .load_bit (data_i[k]),
            .shift_in (shift_in_s),
            .q        (sr_r[k])
        );
    end

    // Serial outputs come straight from flops; ser_o is qualified by state.
    always_comb begin
        ser_o   = sr_r[WIDTH-1] & shifting_s;
        frame_o = shifting_s;
        ready_o = ready_s;
    end

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx (WIDTH=8 and WIDTH=2 instances).
module tb_piso_tx;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       ser;
    logic       frame;
    logic [1:0] data2;
    logic       valid2;
    logic       ready2;
    logic       ser2;
    logic       frame2;

    int checks = 0;
    int errors = 0;

    piso_tx #(.WIDTH(8)) u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .data_i  (data),
        .valid_i (valid),
        .ready_o (ready),
        .ser_o   (ser),
        .frame_o (frame)
    );

    piso_tx #(.WIDTH(2)) u_dut2 (
        .clk_i   (clk),
        .rst_i   (rst),
        .data_i  (data2),
        .valid_i (valid2),
        .ready_o (ready2),
        .ser_o   (ser2),
        .frame_o (frame2)
    );

    always #5 clk = ~clk;

    // Reset holds outputs low and ready low; ready rises when reset drops.
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({ser, frame, ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold: got ser/frame/ready=%b want 000", {ser, frame, ready});
        end
        checks++;
        if ({ser2, frame2, ready2} !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold_w2: got ser/frame/ready=%b want 000", {ser2, frame2, ready2});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({ser, frame, ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_release: got ser/frame/ready=%b want 001", {ser, frame, ready});
        end
    endtask

    // No valid for five cycles: stays idle and ready.
    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({ser, frame, ready} !== 3'b001) begin
                errors++;
                $display("FAIL stall cyc%0d: got ser/frame/ready=%b want 001", i, {ser, frame, ready});
            end
        end
    endtask

    // One word 8'hA5: bits 1,0,1,0,0,1,0,1, ready only in the last bit.
    task automatic test_single();
        logic [7:0] w;
        logic [2:0] exp;
        w = 8'hA5;
        data  = w;
        valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            valid = 1'b0;
            exp = {w[7-i], 1'b1, (i == 7)};
            checks++;
            if ({ser, frame, ready} !== exp) begin
                errors++;
                $display("FAIL single bit%0d: got ser/frame/ready=%b want %b", i, {ser, frame, ready}, exp);
            end
        end
        @(negedge clk);
        checks++;
        if ({ser, frame, ready} !== 3'b001) begin
            errors++;
            $display("FAIL single_end: got ser/frame/ready=%b want 001", {ser, frame, ready});
        end
    endtask

    // 8'hFF then 8'h00 offered continuously: 16 frame cycles, no gap.
    task automatic test_back_to_back();
        logic [2:0] exp;
        data  = 8'hFF;
        valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) begin
                data = 8'h00;
            end
            if (i == 8) begin
                valid = 1'b0;
            end
            exp = {(i < 8), 1'b1, (i == 7 || i == 15)};
            checks++;
            if ({ser, frame, ready} !== exp) begin
                errors++;
                $display("FAIL b2b cyc%0d: got ser/frame/ready=%b want %b", i, {ser, frame, ready}, exp);
            end
        end
        @(negedge clk);
        checks++;
        if ({ser, frame, ready} !== 3'b001) begin
            errors++;
            $display("FAIL b2b_end: got ser/frame/ready=%b want 001", {ser, frame, ready});
        end
    endtask

    // 8'h7E offered from cycle 3 of an 8'h81 frame is taken only at the last bit.
    task automatic test_ignored();
        logic [15:0] w;
        logic [2:0]  exp;
        w = 16'h817E;
        data  = 8'h81;
        valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0 || i == 8) begin
                valid = 1'b0;
            end
            if (i == 2) begin
                data  = 8'h7E;
                valid = 1'b1;
            end
            exp = {w[15-i], 1'b1, (i == 7 || i == 15)};
            checks++;
            if ({ser, frame, ready} !== exp) begin
                errors++;
                $display("FAIL ignored cyc%0d: got ser/frame/ready=%b want %b", i, {ser, frame, ready}, exp);
            end
        end
        @(negedge clk);
        checks++;
        if ({ser, frame, ready} !== 3'b001) begin
            errors++;
            $display("FAIL ignored_end: got ser/frame/ready=%b want 001", {ser, frame, ready});
        end
    endtask

    // Reset during bit 4 of 8'hC3 aborts the frame and drops a coincident offer.
    task automatic test_reset_mid();
        logic [7:0] w;
        logic [2:0] exp;
        w = 8'hC3;
        data  = w;
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            valid = 1'b0;
            if (i == 3) begin
                rst   = 1'b1;
                data  = 8'h55;
                valid = 1'b1;
                #1;
            end
            exp = {w[7-i], 1'b1, 1'b0};
            checks++;
            if ({ser, frame, ready} !== exp) begin
                errors++;
                $display("FAIL rstmid bit%0d: got ser/frame/ready=%b want %b", i, {ser, frame, ready}, exp);
            end
        end
        @(negedge clk);
        rst   = 1'b0;
        valid = 1'b0;
        #1;
        checks++;
        if ({ser, frame, ready} !== 3'b001) begin
            errors++;
            $display("FAIL rstmid_after: got ser/frame/ready=%b want 001", {ser, frame, ready});
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({ser, frame, ready} !== 3'b001) begin
                errors++;
                $display("FAIL rstmid_dropped: got ser/frame/ready=%b want 001", {ser, frame, ready});
            end
        end
    endtask

    // WIDTH=2: 2'b10 then 2'b01 back-to-back gives 1,0,0,1 with no gap.
    task automatic test_width2();
        logic [3:0] w;
        logic [2:0] exp;
        w = 4'b1001;
        data2  = 2'b10;
        valid2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                data2 = 2'b01;
            end
            if (i == 2) begin
                valid2 = 1'b0;
            end
            exp = {w[3-i], 1'b1, (i == 1 || i == 3)};
            checks++;
            if ({ser2, frame2, ready2} !== exp) begin
                errors++;
                $display("FAIL w2 cyc%0d: got ser/frame/ready=%b want %b", i, {ser2, frame2, ready2}, exp);
            end
        end
        @(negedge clk);
        checks++;
        if ({ser2, frame2, ready2} !== 3'b001) begin
            errors++;
            $display("FAIL w2_end: got ser/frame/ready=%b want 001", {ser2, frame2, ready2});
        end
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        data   = 8'h00;
        valid  = 1'b0;
        data2  = 2'b00;
        valid2 = 1'b0;
        test_reset();
        test_stall();
        test_single();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
        test_width2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
